// File: rtl/multi_timer_pkg.sv
// -----------------------------------------------------------------------------
// multi_timer_pkg
//   Shared types for the multi-channel system timer.
//   - mode_e       : per-channel operating mode, decoded from the periodic input
//   - chan_state_t : architectural state of one channel at the default width
//   - TIMER_WIDTH  : default counter/reload width
// -----------------------------------------------------------------------------
package multi_timer_pkg;

    localparam int TIMER_WIDTH = 16;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_e;

    typedef struct packed {
        logic [TIMER_WIDTH-1:0] count;
        logic                   running;
    } chan_state_t;

endpackage

// File: rtl/timer_channel.sv
// -----------------------------------------------------------------------------
// timer_channel
//   One down-counting timer channel. Priority per clock: stop > start > tick.
//   On a tick at count 0 the channel expires: a one-cycle expired pulse, the
//   sticky irq is set, and the channel either reloads (periodic) or halts.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   tick       in   shared prescale enable
//   start      in   load reload value and run
//   stop       in   halt, hold count
//   periodic   in   1 = reload on expiry, 0 = stop on expiry
//   reload     in   WIDTH-bit reload value
//   irq_clear  in   clear sticky irq (a same-cycle expiry wins)
//   count      out  current count
//   running    out  channel is counting
//   expired    out  one-cycle expiry pulse
//   irq        out  sticky expiry flag
// -----------------------------------------------------------------------------
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [WIDTH-1:0] reload,
    input  logic             irq_clear,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             irq
);

    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic             running;
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   expired_d;
    logic   irq_d;
    mode_e  mode;

    assign mode = periodic ? MODE_PERIODIC : MODE_ONESHOT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= '0;
            expired <= 1'b0;
            irq     <= 1'b0;
        end else begin
            state_q <= state_d;
            expired <= expired_d;
            irq     <= irq_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        expired_d = 1'b0;
        irq_d     = irq & ~irq_clear;

        if (stop) begin
            state_d.running = 1'b0;
        end else if (start) begin
            state_d.count   = reload;
            state_d.running = 1'b1;
        end else if (state_q.running && tick) begin
            if (state_q.count != '0) begin
                state_d.count = state_q.count - 1'b1;
            end else begin
                // Expiry: the irq set overrides a same-cycle irq_clear.
                expired_d = 1'b1;
                irq_d     = 1'b1;
                if (mode == MODE_PERIODIC) begin
                    state_d.count = reload;
                end else begin
                    state_d.running = 1'b0;
                end
            end
        end
    end

    assign count   = state_q.count;
    assign running = state_q.running;

endmodule

// File: rtl/multi_timer.sv
// -----------------------------------------------------------------------------
// multi_timer
//   CHANNELS independent programmable down-counting timers sharing one clock
//   and one prescale tick. Pure structural wrapper around timer_channel.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   tick       in   shared prescale enable
//   start      in   [CHANNELS]        per-channel start
//   stop       in   [CHANNELS]        per-channel stop
//   periodic   in   [CHANNELS]        per-channel mode (1 = periodic)
//   reload     in   [CHANNELS*WIDTH]  channel c at [c*WIDTH +: WIDTH]
//   irq_clear  in   [CHANNELS]        per-channel irq clear
//   count      out  [CHANNELS*WIDTH]  channel c at [c*WIDTH +: WIDTH]
//   running    out  [CHANNELS]
//   expired    out  [CHANNELS]        one-cycle expiry pulses
//   irq        out  [CHANNELS]        sticky expiry flags
// -----------------------------------------------------------------------------
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = TIMER_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      tick,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       periodic,
    input  logic [CHANNELS*WIDTH-1:0] reload,
    input  logic [CHANNELS-1:0]       irq_clear,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       running,
    output logic [CHANNELS-1:0]       expired,
    output logic [CHANNELS-1:0]       irq
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        timer_channel #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .tick      (tick),
            .start     (start[c]),
            .stop      (stop[c]),
            .periodic  (periodic[c]),
            .reload    (reload[c*WIDTH +: WIDTH]),
            .irq_clear (irq_clear[c]),
            .count     (count[c*WIDTH +: WIDTH]),
            .running   (running[c]),
            .expired   (expired[c]),
            .irq       (irq[c])
        );
    end

endmodule

// File: tb/tb_multi_timer.sv
// -----------------------------------------------------------------------------
// tb_multi_timer
//   Self-checking bench for multi_timer: directed scenarios with literal
//   expectations, then randomized traffic against a behavioural model.
// -----------------------------------------------------------------------------
module tb_multi_timer;

    localparam int CH = 4;
    localparam int W  = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            tick;
    logic [CH-1:0]   start, stop, periodic, irq_clear;
    logic [CH*W-1:0] reload;
    logic [CH*W-1:0] count;
    logic [CH-1:0]   running, expired, irq;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    multi_timer #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .start     (start),
        .stop      (stop),
        .periodic  (periodic),
        .reload    (reload),
        .irq_clear (irq_clear),
        .count     (count),
        .running   (running),
        .expired   (expired),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: per channel, an integer "remaining ticks" value plus
    // run / pulse / sticky flags, advanced once per clock from the inputs.
    int unsigned m_cnt [CH];
    bit          m_run [CH];
    bit          m_exp [CH];
    bit          m_irq [CH];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CH; c++) begin
                m_cnt[c] = 0; m_run[c] = 0; m_exp[c] = 0; m_irq[c] = 0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                bit fire;
                fire = m_run[c] && tick && !start[c] && !stop[c] && (m_cnt[c] == 0);
                if (stop[c]) m_run[c] = 0;
                else if (start[c]) begin
                    m_cnt[c] = reload[c*W +: W];
                    m_run[c] = 1;
                end else if (m_run[c] && tick) begin
                    if (m_cnt[c] > 0) m_cnt[c] = m_cnt[c] - 1;
                    else if (periodic[c]) m_cnt[c] = reload[c*W +: W];
                    else m_run[c] = 0;
                end
                m_exp[c] = fire;
                m_irq[c] = fire ? 1'b1 : (m_irq[c] && !irq_clear[c]);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare process: every negedge, whole output vectors against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [CH*W-1:0] e_cnt;
            logic [CH-1:0]   e_run, e_exp, e_irq;
            for (int c = 0; c < CH; c++) begin
                e_cnt[c*W +: W] = m_cnt[c][W-1:0];
                e_run[c] = m_run[c];
                e_exp[c] = m_exp[c];
                e_irq[c] = m_irq[c];
            end
            check("model_count",   64'(count),   64'(e_cnt));
            check("model_running", 64'(running), 64'(e_run));
            check("model_expired", 64'(expired), 64'(e_exp));
            check("model_irq",     64'(irq),     64'(e_irq));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [63:0] cnt_of(input int c);
        return 64'(count[c*W +: W]);
    endfunction

    initial begin
        int pulses;
        reset_n = 0; tick = 0; start = 0; stop = 0; periodic = 0;
        irq_clear = 0; reload = '0;
        repeat (2) step();
        reset_n = 1;
        chk_en = 1;
        check("reset_count",   64'(count),   64'd0);
        check("reset_running", 64'(running), 64'd0);
        check("reset_irq",     64'(irq),     64'd0);

        // 1. asynchronous reset mid-count
        reload[0*W +: W] = 16'd5; start = 4'b0001;
        step(); start = 0;
        check("t1_loaded_count", cnt_of(0), 64'd5);
        check("t1_loaded_run", 64'(running[0]), 64'd1);
        @(posedge clk); #2;
        reset_n = 0; #1;
        check("t1_async_count",   64'(count),   64'd0);
        check("t1_async_running", 64'(running), 64'd0);
        check("t1_async_expired", 64'(expired), 64'd0);
        check("t1_async_irq",     64'(irq),     64'd0);
        #1 reset_n = 1;
        step();

        // 2. one-shot, reload 3, tick held high
        reload[0*W +: W] = 16'd3; periodic[0] = 0; start[0] = 1; tick = 1;
        step(); start = 0;
        check("t2_count3", cnt_of(0), 64'd3);
        step(); check("t2_count2", cnt_of(0), 64'd2);
        step(); check("t2_count1", cnt_of(0), 64'd1);
        step(); check("t2_count0", cnt_of(0), 64'd0);
        check("t2_no_exp_yet", 64'(expired[0]), 64'd0);
        step();
        check("t2_expired", 64'(expired[0]), 64'd1);
        check("t2_stopped", 64'(running[0]), 64'd0);
        check("t2_irq",     64'(irq[0]),     64'd1);
        step();
        check("t2_pulse_one_cycle", 64'(expired[0]), 64'd0);
        check("t2_count_holds", cnt_of(0), 64'd0);
        irq_clear[0] = 1; step(); irq_clear = 0;
        check("t2_irq_cleared", 64'(irq[0]), 64'd0);

        // 3. periodic, reload 2, nine tick cycles
        tick = 0; reload[1*W +: W] = 16'd2; periodic[1] = 1; start[1] = 1;
        step(); start = 0; tick = 1;
        pulses = 0;
        repeat (9) begin
            step();
            pulses += int'(expired[1]);
        end
        check("t3_pulses", 64'(pulses), 64'd3);
        check("t3_running", 64'(running[1]), 64'd1);
        tick = 0; stop[1] = 1; step(); stop = 0;

        // 4. periodic, reload 0: expiry every tick; set beats clear
        reload[2*W +: W] = 16'd0; periodic[2] = 1; start[2] = 1;
        step(); start = 0; tick = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_exp_every_tick", 64'(expired[2]), 64'd1);
        end
        irq_clear[2] = 1; step();
        check("t4_set_wins", 64'(irq[2]), 64'd1);
        tick = 0; step();
        check("t4_clear_no_tick", 64'(irq[2]), 64'd0);
        irq_clear = 0;

        // 5. priority cases
        reload[2*W +: W] = 16'd5; start[2] = 1; tick = 1;
        step(); start = 0; tick = 0;
        check("t5_start_over_tick", cnt_of(2), 64'd5);
        check("t5_no_exp", 64'(expired[2]), 64'd0);
        reload[3*W +: W] = 16'd7; start[3] = 1;
        step();
        reload[3*W +: W] = 16'd9; stop[3] = 1;
        step(); start = 0; stop = 0;
        check("t5_stop_over_start_run", 64'(running[3]), 64'd0);
        check("t5_stop_over_start_cnt", cnt_of(3), 64'd7);
        stop = 4'b0100; step(); stop = 0;

        // 6. independence: ch0 periodic reload 1, ch1 one-shot reload 4
        reload[0*W +: W] = 16'd1; periodic[0] = 1;
        reload[1*W +: W] = 16'd4; periodic[1] = 0;
        start = 4'b0011; step(); start = 0;
        for (int i = 0; i < 16; i++) begin
            tick = (i % 2 == 0);
            stop[0] = (i == 6);
            step();
            if (i == 6) begin
                check("t6_ch0_stopped", 64'(running[0]), 64'd0);
                check("t6_ch1_unaffected", 64'(running[1]), 64'd1);
            end
        end
        stop = 0; tick = 0;
        check("t6_ch1_done", 64'(running[1]), 64'd0);
        check("t6_ch1_irq", 64'(irq[1]), 64'd1);

        // Randomized traffic, checked by the compare process each cycle
        for (int i = 0; i < 3000; i++) begin
            tick = 1'($urandom % 2);
            for (int c = 0; c < CH; c++) begin
                start[c]     = ($urandom % 16) == 0;
                stop[c]      = ($urandom % 32) == 0;
                irq_clear[c] = ($urandom % 8) == 0;
                if (($urandom % 8) == 0) periodic[c] = 1'($urandom % 2);
                if (($urandom % 64) == 0) reload[c*W +: W] = 16'hFFFF;
                else if (($urandom % 8) == 0) reload[c*W +: W] = 16'($urandom % 8);
            end
            step();
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
